// File: rtl/timebase_display_pkg.sv
// timebase_display_pkg: rate-select codes, digit count and seven-segment decode shared by the timebase front end.
package timebase_display_pkg;
  typedef enum logic [2:0] {X16, X8, X4, X2, X1} rate_t;
  localparam int NUM_DIGITS = 6;
  function automatic logic [0:6] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b0000001;
      4'd1: seg7 = 7'b1001111;
      4'd2: seg7 = 7'b0010010;
      4'd3: seg7 = 7'b0000110;
      4'd4: seg7 = 7'b1001100;
      4'd5: seg7 = 7'b0100100;
      4'd6: seg7 = 7'b0100000;
      4'd7: seg7 = 7'b0001111;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction
endpackage

// File: rtl/timebase_display_if.sv
// timebase_display_if: rate select, buttons, time value, ticks, press levels and display drive.
interface timebase_display_if;
  logic [2:0] accel;
  logic btn_test;
  logic btn_rst;
  logic [17:0] num;
  logic tick_1s;
  logic tick_var;
  logic test_press;
  logic rst_press;
  logic [0:6] sseg;
  logic [5:0] an;
  modport master(output accel, btn_test, btn_rst, num, input tick_1s, tick_var, test_press, rst_press, sseg, an);
  modport slave(input accel, btn_test, btn_rst, num, output tick_1s, tick_var, test_press, rst_press, sseg, an);
endinterface

// File: rtl/timebase_display_hold_detector.sv
// hold_detector: synchronizes a button and raises press once it has been held through HOLD_SEC one-second ticks.
module hold_detector #(
  parameter int HOLD_SEC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic tick,
  output logic press
);
  localparam int HW = $clog2(HOLD_SEC + 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_SEC);
  logic [1:0] sync_q, sync_d;
  logic [HW-1:0] cnt_q, cnt_d;
  always_comb begin
    sync_d = {sync_q[0], btn};
    cnt_d = !sync_q[1] ? '0 : (tick && cnt_q != HMAX) ? cnt_q + 1'b1 : cnt_q;
    press = cnt_q == HMAX;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/timebase_display.sv
// timebase_display: 1 Hz and rate-scaled tick enables, long-press detection and hh:mm:ss display scan.
module timebase_display
  import timebase_display_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int HOLD_SEC = 4,
  parameter int SCAN_DIV = 50_000
) (
  input logic clk,
  input logic rst,
  timebase_display_if.slave bus
);
  localparam int CW = $clog2(CLK_HZ + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  logic [CW-1:0] sec_q, sec_d, var_q, var_d, per_m1;
  logic [SW-1:0] scan_q, scan_d;
  logic [2:0] dig_q, dig_d, acc_s, accel_q;
  logic [5:0] fld;
  logic tick_1s, tick_var, acc_chg, scan_wrap;
  always_comb begin
    acc_s = bus.accel > 3'(X1) ? 3'(X1) : bus.accel;
    acc_chg = acc_s != accel_q;
    per_m1 = (CW'(CLK_HZ) >> (3'(X1) - acc_s)) - 1'b1;
    tick_1s = sec_q == CW'(CLK_HZ - 1);
    tick_var = !acc_chg && var_q == per_m1;
    sec_d = tick_1s ? '0 : sec_q + 1'b1;
    var_d = (acc_chg || tick_var) ? '0 : var_q + 1'b1;
    scan_wrap = scan_q == SW'(SCAN_DIV - 1);
    scan_d = scan_wrap ? '0 : scan_q + 1'b1;
    dig_d = scan_wrap ? (dig_q == 3'(NUM_DIGITS - 1) ? '0 : dig_q + 1'b1) : dig_q;
    fld = dig_q[2] ? bus.num[17:12] : dig_q[1] ? bus.num[11:6] : bus.num[5:0];
    bus.sseg = seg7(4'(dig_q[0] ? fld / 6'd10 : fld % 6'd10));
    bus.an = ~(6'b1 << dig_q);
    bus.tick_1s = tick_1s;
    bus.tick_var = tick_var;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_q <= '0;
      var_q <= '0;
      scan_q <= '0;
      dig_q <= '0;
    end else begin
      sec_q <= sec_d;
      var_q <= var_d;
      scan_q <= scan_d;
      dig_q <= dig_d;
    end
  end
  // Tracks accel through reset too, so a steady setting is not seen as a change on release.
  always_ff @(posedge clk) accel_q <= acc_s;
  hold_detector #(.HOLD_SEC(HOLD_SEC)) u_test (.clk(clk), .rst(rst), .btn(bus.btn_test), .tick(tick_1s), .press(bus.test_press));
  hold_detector #(.HOLD_SEC(HOLD_SEC)) u_rst (.clk(clk), .rst(rst), .btn(bus.btn_rst), .tick(tick_1s), .press(bus.rst_press));
endmodule

// File: tb/tb_timebase_display.sv
// tb_timebase_display: scoreboard bench; expected event cycles and display values are queued as stimulus is planned.
module tb_timebase_display;
  logic clk = 0;
  logic rst = 1;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int q_t1[$], q_tv[$], q_tp[$], q_rp[$], q_dc[$], q_dv[$];
  int digs[6];
  logic tp_prev = 0, rp_prev = 0;
  logic [5:0] an_prev = 6'b111110;

  timebase_display_if b();
  timebase_display #(.CLK_HZ(64), .HOLD_SEC(4), .SCAN_DIV(4)) dut (.clk(clk), .rst(rst), .bus(b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [6:0] seg_exp(int d);
    case (d)
      0: seg_exp = 7'b0000001;
      1: seg_exp = 7'b1001111;
      2: seg_exp = 7'b0010010;
      3: seg_exp = 7'b0000110;
      4: seg_exp = 7'b1001100;
      5: seg_exp = 7'b0100100;
      6: seg_exp = 7'b0100000;
      7: seg_exp = 7'b0001111;
      8: seg_exp = 7'b0000000;
      9: seg_exp = 7'b0000100;
      default: seg_exp = 7'b1111111;
    endcase
  endfunction

  function automatic logic [5:0] an_exp(int k);
    an_exp = 6'b111111;
    an_exp[k] = 1'b0;
  endfunction

  task automatic push_disp(int upto);
    for (int k = 1; 4 * k < upto; k++) begin
      q_dc.push_back(4 * k);
      q_dv.push_back(int'({an_exp(k % 6), seg_exp(digs[k % 6])}));
    end
  endtask

  task automatic at(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset(logic [6:0] seg);
    check("rst_tick_1s", b.tick_1s, 0);
    check("rst_tick_var", b.tick_var, 0);
    check("rst_test_press", b.test_press, 0);
    check("rst_rst_press", b.rst_press, 0);
    check("rst_an", b.an, 6'b111110);
    check("rst_sseg", b.sseg, seg);
  endtask

  task automatic check_empty();
    check("t1_left", q_t1.size(), 0);
    check("tv_left", q_tv.size(), 0);
    check("tp_left", q_tp.size(), 0);
    check("rp_left", q_rp.size(), 0);
    check("disp_left", q_dc.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      tp_prev = b.test_press;
      rp_prev = b.rst_press;
      an_prev = b.an;
    end else begin
      if (b.tick_1s) check("tick_1s_cycle", cyc, q_t1.size() != 0 ? q_t1.pop_front() : -1);
      if (b.tick_var) check("tick_var_cycle", cyc, q_tv.size() != 0 ? q_tv.pop_front() : -1);
      if (b.test_press != tp_prev) check("test_press_edge", cyc, q_tp.size() != 0 ? q_tp.pop_front() : -1);
      if (b.rst_press != rp_prev) check("rst_press_edge", cyc, q_rp.size() != 0 ? q_rp.pop_front() : -1);
      if (b.an != an_prev) begin
        check("disp_cycle", cyc, q_dc.size() != 0 ? q_dc.pop_front() : -1);
        check("disp_value", {b.an, b.sseg}, q_dv.size() != 0 ? q_dv.pop_front() : -1);
      end
      tp_prev = b.test_press;
      rp_prev = b.rst_press;
      an_prev = b.an;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    b.accel = 3'd4;
    b.btn_test = 0;
    b.btn_rst = 0;
    b.num = {6'd12, 6'd34, 6'd56};
    digs = '{6, 5, 4, 3, 2, 1};
    repeat (3) @(posedge clk);
    #1;
    check_reset(seg_exp(6));
    for (int k = 0; k < 20; k++) q_t1.push_back(63 + 64 * k);
    q_tv = '{63, 127, 134, 138, 142, 146, 150, 216, 248};
    for (int k = 0; k < 16; k++) q_tv.push_back(314 + 64 * k);
    q_tp = '{512, 623};
    q_rp = '{1280};
    push_disp(1300);
    rst = 0;
    at(130); b.accel = 3'd0;
    at(152); b.accel = 3'd7;
    at(240); b.accel = 3'd1;
    at(250); b.accel = 3'd4;
    at(300); b.btn_test = 1;
    at(620); b.btn_test = 0;
    at(640); b.btn_test = 1;
    at(832); b.btn_test = 0;
    at(880); b.btn_rst = 1;
    at(893); b.btn_rst = 0;
    at(944); b.btn_rst = 1;
    at(957); b.btn_rst = 0;
    at(1008); b.btn_rst = 1;
    at(1021); b.btn_rst = 0;
    at(1030); b.btn_rst = 1;
    at(1300);
    check_empty();
    rst = 1;
    #1;
    check_reset(seg_exp(6));
    b.btn_rst = 0;
    b.num = {6'd63, 6'd9, 6'd60};
    #1;
    check("rst_sseg_num2", b.sseg, seg_exp(0));
    digs = '{0, 6, 9, 0, 3, 6};
    q_t1 = '{63, 127, 191};
    q_tv = '{63, 127, 191};
    push_disp(200);
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    at(200);
    check_empty();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
